// File: rtl/bank_read_scheduler_pkg.sv
// ============================================================================
// Module   : bank_read_scheduler_pkg
// Brief    : Shared helpers for the banked read scheduler (clog2, bank select).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bank_read_scheduler_pkg;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Bank index held in the low bsel_w bits of a requester word address.
  function automatic int bank_sel_f(input logic [63:0] addr, input int bsel_w);
    logic [63:0] mask;
    mask = (64'd1 << bsel_w) - 64'd1;
    return int'(addr & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bank_read_scheduler_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : N-way round-robin arbiter with one-hot grant and internal pointer.
//            The search starts at the pointer; after a grant the pointer moves
//            to the slot after the winner, otherwise it holds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import bank_read_scheduler_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (clog2_f(N) < 1) ? 1 : clog2_f(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found_w;
  int            idx_w;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_o   = '0;
    ptr_d   = ptr_q;
    found_w = 1'b0;
    idx_w   = 0;
    for (int i = 0; i < N; i++) begin
      idx_w = (int'(ptr_q) + i) % N;
      if (!found_w && req_i[idx_w]) begin
        found_w      = 1'b1;
        gnt_o[idx_w] = 1'b1;
        ptr_d        = PW'((idx_w + 1) % N);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bank_read_scheduler.sv
// ============================================================================
// Module   : bank_read_scheduler
// Brief    : Schedules REQS read requesters onto BANKS single-read-port BRAM
//            banks. Each bank runs its own round-robin arbiter; a per-requester
//            tag remembers which bank to take read data from one cycle later.
// Options  : BANK_READ_SCHEDULER_OUTREG_EN - adds one response register stage
//            (latency 2 instead of 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_read_scheduler
  import bank_read_scheduler_pkg::*;
#(
  parameter  int BANKS      = 4,
  parameter  int REQS       = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 16,
  localparam int BSEL_WIDTH = clog2_f(BANKS),
  localparam int RA_WIDTH   = ADDR_WIDTH + BSEL_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQS-1:0]              req_valid_i,
  input  logic [REQS*RA_WIDTH-1:0]     req_addr_i,
  output logic [REQS-1:0]              req_ready_o,
  output logic [REQS-1:0]              rsp_valid_o,
  output logic [REQS*DATA_WIDTH-1:0]   rsp_data_o,
  output logic [BANKS-1:0]             bank_rden_o,
  output logic [BANKS*ADDR_WIDTH-1:0]  bank_addr_o,
  input  logic [BANKS*DATA_WIDTH-1:0]  bank_dout_i
);

  logic [RA_WIDTH-1:0]   ra_w     [REQS];
  logic [DATA_WIDTH-1:0] dout_w   [BANKS];
  logic [REQS-1:0]       breq_w   [BANKS];
  logic [REQS-1:0]       gnt_w    [BANKS];

  logic [REQS-1:0]       tag_valid_q;
  logic [REQS-1:0]       tag_valid_d;
  logic [BSEL_WIDTH-1:0] tag_bank_q [REQS];
  logic [BSEL_WIDTH-1:0] tag_bank_d [REQS];

  logic [REQS-1:0]            rsp_valid_d;
  logic [REQS*DATA_WIDTH-1:0] rsp_data_d;

  genvar gr, gb;

  generate
    for (gr = 0; gr < REQS; gr++) begin : g_req
      assign ra_w[gr] = req_addr_i[gr*RA_WIDTH +: RA_WIDTH];
    end

    for (gb = 0; gb < BANKS; gb++) begin : g_bank
      assign dout_w[gb] = bank_dout_i[gb*DATA_WIDTH +: DATA_WIDTH];

      rr_arbiter #(
        .N (REQS)
      ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (breq_w[gb]),
        .gnt_o (gnt_w[gb])
      );
    end
  endgenerate

  // Route each valid request to the arbiter of the bank it addresses; nothing
  // is offered while reset is held so no grant can appear during reset.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      for (int r = 0; r < REQS; r++) begin
        breq_w[b][r] = req_valid_i[r] & ~rst &
                       (bank_sel_f(64'(ra_w[r]), BSEL_WIDTH) == b);
      end
    end
  end

  // Drive bank read ports from the winners and collect per-requester readies.
  always_comb begin
    req_ready_o = '0;
    bank_rden_o = '0;
    bank_addr_o = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_rden_o[b] = |gnt_w[b];
      for (int r = 0; r < REQS; r++) begin
        if (gnt_w[b][r]) begin
          req_ready_o[r] = 1'b1;
          bank_addr_o[b*ADDR_WIDTH +: ADDR_WIDTH] = ra_w[r][RA_WIDTH-1:BSEL_WIDTH];
        end
      end
    end
  end

  // Next tag: valid on grant, bank index captured from the granted address.
  always_comb begin
    tag_valid_d = req_ready_o;
    for (int r = 0; r < REQS; r++) begin
      tag_bank_d[r] = req_ready_o[r] ? ra_w[r][BSEL_WIDTH-1:0] : tag_bank_q[r];
    end
  end

  // Tag registers; reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_q <= '0;
      for (int r = 0; r < REQS; r++) begin
        tag_bank_q[r] <= '0;
      end
    end else begin
      tag_valid_q <= tag_valid_d;
      for (int r = 0; r < REQS; r++) begin
        tag_bank_q[r] <= tag_bank_d[r];
      end
    end
  end

  // Steer the tagged bank's data to each requester; zero when no response.
  always_comb begin
    rsp_valid_d = tag_valid_q;
    rsp_data_d  = '0;
    for (int r = 0; r < REQS; r++) begin
      if (tag_valid_q[r]) begin
        rsp_data_d[r*DATA_WIDTH +: DATA_WIDTH] = dout_w[tag_bank_q[r]];
      end
    end
  end

`ifdef BANK_READ_SCHEDULER_OUTREG_EN
  logic [REQS-1:0]            rsp_valid_q;
  logic [REQS*DATA_WIDTH-1:0] rsp_data_q;

  // Extra response stage to break the bank-data to requester timing path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
`else
  assign rsp_valid_o = rsp_valid_d;
  assign rsp_data_o  = rsp_data_d;
`endif

endmodule

`default_nettype wire
